led_fade_driver: RTL and testbench
==================================

// Module: led_fade_driver
// PURPOSE
//   Downstream LED output stage. Consumes the 8-bit on/off pattern from the LED PIO register (out_port)
//   and drives the board LED pins with a PWM signal. Each LED fades linearly up or down whenever its
//   target bit changes. When fading is disabled, the LEDs follow the pattern directly (bypass).
// PARAMETERS
//   N_LED      8   number of LED channels (width of led_in / led_out)
//   PWM_BITS   8   PWM resolution; MAX = 2**PWM_BITS-1 is full-on level
//   PRESCALE   50  clk cycles per PWM count step (>=1)
//   FADE_STEP  4   level change per PWM period while fading (1..MAX)
// PORTS
//   clk       in   1      system clock; single clock domain
//   reset     in   1      synchronous, active-high reset
//   led_in    in   N_LED  target pattern from the LED PIO; 1 = LED on
//   fade_en   in   1      1 = fade toward target; 0 = bypass (level jumps to target)
//   led_out   out  N_LED  PWM-modulated LED drive, registered
//   busy      out  1      1 while any channel is in RISE or FALL state, registered
// BEHAVIOUR
//   - Reset (sync, high): led_q, pwm_cnt, presc_cnt, all levels = 0; all states = OFF; led_out = 0; busy = 0.
//     Reset asserted mid-fade aborts the fade; outputs are 0 on the clock edge after reset is sampled.
//   - led_in and fade_en are registered once (led_q, fade_q) before use. There is no CDC logic; both
//     inputs are synchronous to clk.
//   - Prescaler: presc_cnt counts 0..PRESCALE-1 and wraps; ce = (presc_cnt == PRESCALE-1).
//   - PWM counter: on ce, pwm_cnt counts 0..MAX-1 and wraps to 0. pe (period end) = ce && pwm_cnt == MAX-1.
//     Period length = PRESCALE*MAX clocks.
//   - Output: led_out[i] <= (level[i] > pwm_cnt). Level 0 = constantly low; level MAX = constantly high.
//   - Per-channel FSM, 2-bit state {OFF, RISE, ON, FALL}. Evaluated every clock while fade_q = 1;
//     the level changes only on pe.
//       OFF : tgt=1 -> RISE
//       RISE: on pe, level = min(level+FADE_STEP, MAX); when the new level == MAX -> ON (same edge)
//             tgt=0 -> FALL (reversal starts from the current level; no jump)
//       ON  : tgt=0 -> FALL
//       FALL: on pe, level = max(level-FADE_STEP, 0) (saturating; no underflow); when the new level == 0 -> OFF
//             tgt=1 -> RISE
//   - Arithmetic: computed in PWM_BITS+1 bits, then clamped to the range 0..MAX.
//   - Bypass (fade_q = 0): every clock, level = tgt ? MAX : 0 and state = tgt ? ON : OFF.
//     Latency led_in -> led_out = 3 clk (led_q, level, led_out).
//   - fade_en 1->0 mid-fade: the channel snaps to target on the next clock.
//     fade_en 0->1: fading resumes from the current (settled) level.
//   - Level updates occur only at pe, so the duty never changes inside a PWM period (glitch-free).
//   - busy <= |(state == RISE or FALL) across all channels; it drops on the edge where the last channel
//     reaches ON or OFF.
//   - Simultaneous tgt change and pe on the same clock: the state transition takes effect first.
//     The level step at that pe uses the new direction.
// STRUCTURE
//   - Package led_drv_pkg: state encodings ST_OFF=0, ST_RISE=1, ST_ON=2, ST_FALL=3, and a clamp function.
//   - Top module holds the input registers, the prescaler, pwm_cnt, pe/ce generation, and the busy OR-reduce.
//   - Sub-module led_fade_channel (state, level, compare flop) is instantiated N_LED times via generate.
//     Inputs: tgt, fade_q, pe, pwm_cnt. Outputs: led, fading.
// TESTING  (bench params: PWM_BITS=4 (MAX=15), PRESCALE=2, FADE_STEP=5; period = 30 clk)
//   1 Reset: hold reset 3 clk with led_in=FF -> led_out=00, busy=0, all levels 0 throughout;
//     release -> ramps begin.
//   2 Bypass: fade_en=0, led_in=81 -> led_out=81 steady from clk 3 on, busy never 1.
//   3 Fade-in: fade_en=1, led_in 00->01 -> busy=1; level0 = 5,10,15 at successive pe;
//     led_out[0] duty 5/15, 10/15, then constant 1; busy=0 on the edge where level0 reaches 15.
//   4 Reversal: during RISE at level 10, led_in 01->00 -> state FALL; level 5 at next pe, then 0;
//     state OFF; led_out[0]=0 constant; busy=0.
//   5 Saturation: FADE_STEP=6, fade in -> levels 6,12,15 (clamped).
//     Fade out from 15 -> 9,3,0 (no wrap to 13).
//   6 Mid-fade reset and bypass switch: reset during RISE -> all 0 next clk.
//     fade_en 1->0 at level 5 with tgt=1 -> level 15 next clk; led_out[0]=1 constant.

Source files
------------

// File: rtl/led_drv_pkg.sv
// Shared types and helpers for the LED fade driver: channel state encoding and level clamping.
package led_drv_pkg;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_RISE = 2'd1,
    ST_ON   = 2'd2,
    ST_FALL = 2'd3
  } led_state_e;

  // Saturate a signed intermediate level into 0..max_level.
  function automatic int unsigned clamp_level(input int value, input int unsigned max_level);
    if (value < 0) begin
      return 0;
    end else if (value > int'(max_level)) begin
      return max_level;
    end else begin
      return 32'(value);
    end
  endfunction

endpackage

// File: rtl/led_fade_channel.sv
// One LED channel: fade FSM, brightness level and registered PWM compare.
module led_fade_channel
  import led_drv_pkg::*;
#(
  parameter int unsigned PWM_BITS  = 8,
  parameter int unsigned FADE_STEP = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tgt,
  input  logic                fade_q,
  input  logic                pe,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  output logic                led,
  output logic                fading
);

  localparam int unsigned MAX   = (1 << PWM_BITS) - 1;
  localparam int unsigned SUM_W = PWM_BITS + 1;

  led_state_e          r_state;
  led_state_e          w_state_nxt;
  logic [PWM_BITS-1:0] r_level;
  logic [PWM_BITS-1:0] w_level_nxt;
  logic                r_led;
  logic [SUM_W-1:0]    w_up;
  logic [SUM_W-1:0]    w_dn;

  // One extra bit holds both the overshoot above MAX and the two's-complement undershoot below 0.
  assign w_up = SUM_W'(r_level) + SUM_W'(FADE_STEP);
  assign w_dn = SUM_W'(r_level) - SUM_W'(FADE_STEP);

  always_comb begin
    w_state_nxt = r_state;
    w_level_nxt = r_level;
    if (!fade_q) begin
      w_state_nxt = tgt ? ST_ON : ST_OFF;
      w_level_nxt = tgt ? PWM_BITS'(MAX) : '0;
    end else begin
      unique case (r_state)
        ST_OFF:  if (tgt)  w_state_nxt = ST_RISE;
        ST_RISE: if (!tgt) w_state_nxt = ST_FALL;
        ST_ON:   if (!tgt) w_state_nxt = ST_FALL;
        ST_FALL: if (tgt)  w_state_nxt = ST_RISE;
        default: w_state_nxt = ST_OFF;
      endcase
      // Direction is settled above, so a step on the same pe follows a fresh reversal.
      if (pe) begin
        if (w_state_nxt == ST_RISE) begin
          w_level_nxt = PWM_BITS'(clamp_level(int'(w_up), MAX));
          if (w_level_nxt == PWM_BITS'(MAX)) w_state_nxt = ST_ON;
        end else if (w_state_nxt == ST_FALL) begin
          w_level_nxt = PWM_BITS'(clamp_level(int'($signed(w_dn)), MAX));
          if (w_level_nxt == '0) w_state_nxt = ST_OFF;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_OFF;
      r_level <= '0;
      r_led   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_level <= w_level_nxt;
      r_led   <= (r_level > pwm_cnt);
    end
  end

  assign led    = r_led;
  assign fading = (w_state_nxt == ST_RISE) || (w_state_nxt == ST_FALL);

endmodule

// File: rtl/led_fade_driver.sv
// LED output stage: registers the PIO pattern, runs the shared PWM timebase and fades each LED.
module led_fade_driver
  import led_drv_pkg::*;
#(
  parameter int unsigned N_LED     = 8,
  parameter int unsigned PWM_BITS  = 8,
  parameter int unsigned PRESCALE  = 50,
  parameter int unsigned FADE_STEP = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_LED-1:0] led_in,
  input  logic             fade_en,
  output logic [N_LED-1:0] led_out,
  output logic             busy
);

  localparam int unsigned MAX     = (1 << PWM_BITS) - 1;
  localparam int unsigned PRESC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [N_LED-1:0]    r_led_q;
  logic                r_fade_q;
  logic [PRESC_W-1:0]  r_presc_cnt;
  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic                r_busy;
  logic                w_ce;
  logic                w_pe;
  logic [N_LED-1:0]    w_fading;

  assign w_ce = (r_presc_cnt == PRESC_W'(PRESCALE - 1));
  assign w_pe = w_ce && (r_pwm_cnt == PWM_BITS'(MAX - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_led_q     <= '0;
      r_fade_q    <= 1'b0;
      r_presc_cnt <= '0;
      r_pwm_cnt   <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_led_q     <= led_in;
      r_fade_q    <= fade_en;
      r_presc_cnt <= w_ce ? '0 : r_presc_cnt + PRESC_W'(1);
      if (w_ce) begin
        r_pwm_cnt <= (r_pwm_cnt == PWM_BITS'(MAX - 1)) ? '0 : r_pwm_cnt + PWM_BITS'(1);
      end
      r_busy <= |w_fading;
    end
  end

  for (genvar gi = 0; gi < int'(N_LED); gi++) begin : g_ch
    led_fade_channel #(
      .PWM_BITS (PWM_BITS),
      .FADE_STEP(FADE_STEP)
    ) u_ch (
      .clk    (clk),
      .reset  (reset),
      .tgt    (r_led_q[gi]),
      .fade_q (r_fade_q),
      .pe     (w_pe),
      .pwm_cnt(r_pwm_cnt),
      .led    (led_out[gi]),
      .fading (w_fading[gi])
    );
  end

  assign busy = r_busy;

endmodule

// File: tb/tb_led_fade_driver.sv
// Directed bench for led_fade_driver: MAX=15, PRESCALE=2 (30-clk period), FADE_STEP 5 and 6.
module tb_led_fade_driver;

  logic       clk;
  logic       reset;
  logic [7:0] led_in;
  logic       fade_en;
  logic [7:0] led_out;
  logic       busy;
  logic [7:0] led_in6;
  logic       fade_en6;
  logic [7:0] led_out6;
  logic       busy6;

  int n_assert = 0;
  int n_fail   = 0;
  int tcyc     = 0;

  led_fade_driver #(.N_LED(8), .PWM_BITS(4), .PRESCALE(2), .FADE_STEP(5)) dut (
    .clk(clk), .reset(reset), .led_in(led_in), .fade_en(fade_en), .led_out(led_out), .busy(busy)
  );

  led_fade_driver #(.N_LED(8), .PWM_BITS(4), .PRESCALE(2), .FADE_STEP(6)) dut6 (
    .clk(clk), .reset(reset), .led_in(led_in6), .fade_en(fade_en6), .led_out(led_out6), .busy(busy6)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference timebase: edge k after reset release is a period end when k % 30 == 29.
  always @(posedge clk) begin
    if (reset) tcyc <= 0;
    else       tcyc <= tcyc + 1;
  end

  task automatic do_reset(input logic fe, input logic [7:0] li);
    @(negedge clk);
    reset = 1'b1; fade_en = fe; led_in = li; fade_en6 = fe; led_in6 = li;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_tcyc(input int n);
    int guard = 0;
    while (tcyc != n && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (tcyc != n) begin
      n_assert++; n_fail++;
      $display("FAIL wait_tcyc: reached %0d, required %0d", tcyc, n);
    end
  endtask

  // Count high samples of channel 0 over 30 clocks; a constant level L gives 2*L.
  task automatic measure(input bit use6, output int ones);
    ones = 0;
    repeat (30) begin
      @(negedge clk);
      ones += use6 ? int'(led_out6[0]) : int'(led_out[0]);
    end
  endtask

  task automatic test_reset;
    int ones;
    @(negedge clk);
    reset = 1'b1; fade_en = 1'b1; led_in = 8'hFF; fade_en6 = 1'b1; led_in6 = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_assert++;
      if (led_out !== 8'h00) begin n_fail++; $display("FAIL reset_led cyc%0d: got %h, want 00", i, led_out); end
      n_assert++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy cyc%0d: got %b, want 0", i, busy); end
    end
    reset = 1'b0;
    wait_tcyc(2);
    n_assert++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL reset_ramp_busy: got %b, want 1", busy); end
    wait_tcyc(30);
    measure(1'b0, ones);
    n_assert++;
    if (ones !== 10) begin n_fail++; $display("FAIL reset_ramp_duty: got %0d, want 10", ones); end
  endtask

  task automatic test_bypass;
    do_reset(1'b0, 8'h00);
    led_in = 8'h81;
    wait_tcyc(2);
    n_assert++;
    if (led_out !== 8'h00) begin n_fail++; $display("FAIL bypass_latency: got %h, want 00", led_out); end
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      n_assert++;
      if (led_out !== 8'h81) begin n_fail++; $display("FAIL bypass_led t%0d: got %h, want 81", tcyc, led_out); end
      n_assert++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL bypass_busy t%0d: got %b, want 0", tcyc, busy); end
    end
  endtask

  task automatic test_fade_in;
    int ones;
    do_reset(1'b1, 8'h01);
    wait_tcyc(2);
    n_assert++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL fadein_busy_start: got %b, want 1", busy); end
    wait_tcyc(30);
    measure(1'b0, ones);
    n_assert++;
    if (ones !== 10) begin n_fail++; $display("FAIL fadein_duty5: got %0d, want 10", ones); end
    n_assert++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL fadein_busy_mid: got %b, want 1", busy); end
    measure(1'b0, ones);
    n_assert++;
    if (ones !== 20) begin n_fail++; $display("FAIL fadein_duty10: got %0d, want 20", ones); end
    n_assert++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL fadein_busy_end: got %b, want 0", busy); end
    measure(1'b0, ones);
    n_assert++;
    if (ones !== 30) begin n_fail++; $display("FAIL fadein_full: got %0d, want 30", ones); end
  endtask

  task automatic test_reversal;
    int ones;
    do_reset(1'b1, 8'h01);
    wait_tcyc(60);
    led_in = 8'h00;
    measure(1'b0, ones);
    n_assert++;
    if (ones !== 20) begin n_fail++; $display("FAIL rev_duty10: got %0d, want 20", ones); end
    n_assert++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL rev_busy_mid: got %b, want 1", busy); end
    measure(1'b0, ones);
    n_assert++;
    if (ones !== 10) begin n_fail++; $display("FAIL rev_duty5: got %0d, want 10", ones); end
    n_assert++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rev_busy_end: got %b, want 0", busy); end
    measure(1'b0, ones);
    n_assert++;
    if (ones !== 0) begin n_fail++; $display("FAIL rev_off: got %0d, want 0", ones); end
  endtask

  task automatic test_saturation;
    int ones;
    int exp_up [3] = '{12, 24, 30};
    int exp_dn [4] = '{30, 18, 6, 0};
    do_reset(1'b1, 8'h01);
    wait_tcyc(30);
    for (int i = 0; i < 3; i++) begin
      measure(1'b1, ones);
      n_assert++;
      if (ones !== exp_up[i]) begin n_fail++; $display("FAIL sat_up%0d: got %0d, want %0d", i, ones, exp_up[i]); end
    end
    led_in6 = 8'h00;
    for (int i = 0; i < 4; i++) begin
      measure(1'b1, ones);
      n_assert++;
      if (ones !== exp_dn[i]) begin n_fail++; $display("FAIL sat_dn%0d: got %0d, want %0d", i, ones, exp_dn[i]); end
      if (i == 2) begin
        n_assert++;
        if (busy6 !== 1'b0) begin n_fail++; $display("FAIL sat_busy_end: got %b, want 0", busy6); end
      end
    end
  endtask

  task automatic test_mid_reset_bypass;
    int ones;
    do_reset(1'b1, 8'h01);
    wait_tcyc(35);
    n_assert++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL midrst_busy_pre: got %b, want 1", busy); end
    reset = 1'b1;
    @(negedge clk);
    n_assert++;
    if (led_out !== 8'h00) begin n_fail++; $display("FAIL midrst_led: got %h, want 00", led_out); end
    n_assert++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b, want 0", busy); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    wait_tcyc(30);
    fade_en = 1'b0;
    wait_tcyc(31);
    n_assert++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL snap_busy_pre: got %b, want 1", busy); end
    wait_tcyc(32);
    n_assert++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL snap_busy: got %b, want 0", busy); end
    measure(1'b0, ones);
    n_assert++;
    if (ones !== 30) begin n_fail++; $display("FAIL snap_full: got %0d, want 30", ones); end
  endtask

  task automatic test_resume;
    int ones;
    int exp_dn [4] = '{30, 20, 10, 0};
    wait_tcyc(90);
    fade_en = 1'b1;
    led_in  = 8'h00;
    for (int i = 0; i < 4; i++) begin
      measure(1'b0, ones);
      n_assert++;
      if (ones !== exp_dn[i]) begin n_fail++; $display("FAIL resume_dn%0d: got %0d, want %0d", i, ones, exp_dn[i]); end
      if (i == 1) begin
        n_assert++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL resume_busy_mid: got %b, want 1", busy); end
      end
      if (i == 2) begin
        n_assert++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL resume_busy_end: got %b, want 0", busy); end
      end
    end
  endtask

  initial begin
    reset    = 1'b1;
    led_in   = 8'h00;
    fade_en  = 1'b0;
    led_in6  = 8'h00;
    fade_en6 = 1'b0;
    test_reset();
    test_bypass();
    test_fade_in();
    test_reversal();
    test_saturation();
    test_mid_reset_bypass();
    test_resume();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
